// File: rtl/icache_dm.sv
// rtl/icache_dm.sv - direct-mapped instruction cache with line refill, flush and misalignment faults
module icache_dm #(
  parameter int ADDR_W     = 64,
  parameter int WORD_W     = 32,
  parameter int LINE_WORDS = 4,
  parameter int NUM_LINES  = 64
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              resp_valid,
  output logic [WORD_W-1:0] resp_data,
  output logic              resp_fault,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_resp_valid,
  input  logic [WORD_W-1:0] mem_resp_data
);

  localparam int B_W    = $clog2(WORD_W / 8);
  localparam int WO_W   = $clog2(LINE_WORDS);
  localparam int IDX_W  = $clog2(NUM_LINES);
  localparam int IDX_LO = B_W + WO_W;
  localparam int TAG_W  = ADDR_W - IDX_LO - IDX_W;
  localparam logic [ADDR_W-1:0] BYTE_MASK = ADDR_W'((64'd1 << B_W) - 64'd1);
  localparam logic [ADDR_W-1:0] LINE_MASK = ADDR_W'((64'd1 << IDX_LO) - 64'd1);
  localparam logic [WO_W-1:0]   LAST_BEAT = WO_W'(LINE_WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MEM_REQ,
    S_REFILL,
    S_RESPOND
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [WORD_W-1:0] r_data [NUM_LINES*LINE_WORDS];
  logic [TAG_W-1:0]  r_tag  [NUM_LINES];
  logic [NUM_LINES-1:0] r_valid;

  logic [ADDR_W-1:0] r_addr;
  logic [WO_W-1:0]   r_cnt;
  logic [WORD_W-1:0] r_capture;
  logic              r_flush_pend;
  logic              r_resp_valid;
  logic [WORD_W-1:0] r_resp_data;
  logic              r_resp_fault;

  logic [WO_W-1:0]   w_req_wo;
  logic [IDX_W-1:0]  w_req_idx;
  logic [TAG_W-1:0]  w_req_tag;
  logic [WO_W-1:0]   w_fill_wo;
  logic [IDX_W-1:0]  w_fill_idx;
  logic [TAG_W-1:0]  w_fill_tag;
  logic              w_misaligned;
  logic              w_hit;
  logic              w_accept;
  logic              w_fill_start;
  logic              w_beat;
  logic              w_last;
  logic [WORD_W-1:0] w_hit_word;
  logic [WORD_W-1:0] w_req_word;

  assign w_req_wo   = req_addr[B_W +: WO_W];
  assign w_req_idx  = req_addr[IDX_LO +: IDX_W];
  assign w_req_tag  = req_addr[ADDR_W-1 -: TAG_W];
  assign w_fill_wo  = r_addr[B_W +: WO_W];
  assign w_fill_idx = r_addr[IDX_LO +: IDX_W];
  assign w_fill_tag = r_addr[ADDR_W-1 -: TAG_W];

  assign w_misaligned = (req_addr & BYTE_MASK) != '0;
  assign w_hit        = r_valid[w_req_idx] && (r_tag[w_req_idx] == w_req_tag);
  assign w_accept     = (r_state == S_IDLE) && req_valid;
  assign w_fill_start = w_accept && !w_misaligned && !w_hit;
  assign w_beat       = (r_state == S_REFILL) && mem_resp_valid;
  assign w_last       = w_beat && (r_cnt == LAST_BEAT);
  assign w_hit_word   = r_data[{w_req_idx, w_req_wo}];
  // The requested word may arrive on the final beat itself, so bypass the capture register.
  assign w_req_word   = (r_cnt == w_fill_wo) ? mem_resp_data : r_capture;

  assign resp_valid = r_resp_valid;
  assign resp_data  = r_resp_data;
  assign resp_fault = r_resp_fault;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    req_ready     = 1'b0;
    mem_req_valid = 1'b0;
    mem_req_addr  = '0;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (w_fill_start) w_state_nxt = S_MEM_REQ;
      end
      S_MEM_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = r_addr & ~LINE_MASK;
        if (mem_req_ready) w_state_nxt = S_REFILL;
      end
      S_REFILL: begin
        if (w_last) w_state_nxt = S_RESPOND;
      end
      S_RESPOND: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_addr       <= '0;
      r_cnt        <= '0;
      r_capture    <= '0;
      r_flush_pend <= 1'b0;
      r_valid      <= '0;
      r_resp_valid <= 1'b0;
      r_resp_data  <= '0;
      r_resp_fault <= 1'b0;
    end else begin
      if (w_fill_start) r_addr <= req_addr;

      if (r_state == S_MEM_REQ) begin
        r_cnt <= '0;
      end else if (w_beat) begin
        r_cnt <= r_cnt + WO_W'(1);
      end

      if (w_beat && (r_cnt == w_fill_wo)) r_capture <= mem_resp_data;

      // A flush seen at any point of the refill keeps the new line invalid.
      if (r_state == S_IDLE) begin
        r_flush_pend <= 1'b0;
      end else if (flush && ((r_state == S_MEM_REQ) || (r_state == S_REFILL))) begin
        r_flush_pend <= 1'b1;
      end

      if (flush) r_valid <= '0;
      if (w_last) r_valid[w_fill_idx] <= !(flush || r_flush_pend);

      r_resp_valid <= 1'b0;
      r_resp_data  <= '0;
      r_resp_fault <= 1'b0;
      if (w_accept && w_misaligned) begin
        r_resp_valid <= 1'b1;
        r_resp_fault <= 1'b1;
      end else if (w_accept && w_hit) begin
        r_resp_valid <= 1'b1;
        r_resp_data  <= w_hit_word;
      end else if (w_last) begin
        r_resp_valid <= 1'b1;
        r_resp_data  <= w_req_word;
      end
    end
  end

  // Data and tag storage carry no reset; the valid bits alone qualify them.
  always_ff @(posedge clk) begin
    if (w_beat) r_data[{w_fill_idx, r_cnt}] <= mem_resp_data;
    if (w_last) r_tag[w_fill_idx] <= w_fill_tag;
  end

endmodule
